tb_ctrl_responder: RTL and testbench
====================================

Name: tb_ctrl_responder

Overview:
- Memory-mapped testbench control peripheral on the core data bus (OBI-style req/gnt/rvalid).
- It is the responder that software talks to in order to print characters, signal pass/fail and report an exit code.
- Drives the tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o signals consumed by the top-level testbench exit catcher.
- Buffers stdout characters in a small FIFO toward a ready/valid character sink, and holds termination until the FIFO has drained.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of register 0; 64-byte window, addr_i[5:2] selects the register.
- FIFO_DEPTH, 8, stdout FIFO entries; power of two, 2..64.
- PASS_MAGIC, 32'd123456789, value written to PASSFAIL that means pass.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_i  in  1  bus request
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  grant, combinational
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- stdout_valid_o  out  1  character available
- stdout_data_o  out  8  character
- stdout_ready_i  in  1  sink accepts character
- tests_passed_o  out  1  sticky pass
- tests_failed_o  out  1  sticky fail
- exit_valid_o  out  1  sticky exit
- exit_value_o  out  32  exit code

Interface decision: reset rst_ni, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset values: all outputs 0, FIFO empty, cycle counter 0, FSM in RUN.
- Hit: addr_i[31:6] == BASE_ADDR[31:6]. A miss is still granted; reads return 0 and writes are ignored.
- Register map, by byte offset:
  - 0x00 STDOUT, W: if be_i[0], push wdata_i[7:0]. R: 0.
  - 0x04 EXIT, W: latch wdata_i as the pending exit code.
  - 0x08 PASSFAIL, W: wdata_i == PASS_MAGIC sets pending pass, else pending fail.
  - 0x0C CYCLE, R: free-running 32-bit cycle counter, wraps at 2^32.
  - 0x10 STATUS, R: {fifo_count in [7:0], pending flags in [10:8]}.
- Grant: gnt_o = req_i, except deasserted for a STDOUT write while the FIFO is full and no pop occurs this cycle.
- Response latency: rvalid_o exactly 1 cycle after each granted request, back-to-back allowed. rdata_o is valid with rvalid_o and 0 otherwise.
- FIFO:
  - Push and pop in the same cycle are both allowed.
  - A full FIFO accepts a push if a pop occurs in the same cycle.
  - Pop when stdout_valid_o && stdout_ready_i.
  - stdout_valid_o = !empty; stdout_data_o = head entry.
  - Pointer wrap uses an extra MSB for the full/empty distinction.
- FSM:
  - RUN -> DRAIN on the first accepted EXIT or PASSFAIL write.
  - DRAIN -> DONE when the FIFO is empty.
  - In DONE, the pending flag(s) are asserted on the outputs the cycle after entry and held until reset.
  - In DRAIN or DONE, further EXIT/PASSFAIL writes are granted but ignored; the first event wins. STDOUT writes are still accepted.
  - EXIT and PASSFAIL in successive cycles: only the first counts.
- Outputs are registered; no combinational path exists from bus inputs to the termination outputs.
- Reset mid-DRAIN: FIFO discarded, back to RUN, outputs 0.

Decomposition:
- Package tb_ctrl_pkg holds:
  - register offset localparams (REG_STDOUT, REG_EXIT, REG_PASSFAIL, REG_CYCLE, REG_STATUS);
  - the FSM state enum (RUN, DRAIN, DONE);
  - the default PASS_MAGIC.
- One sub-module: tb_ctrl_fifo (parameterised sync FIFO exposing count, full, empty).

Test Plan:
- Write 0x48, 0x69, 0x0A to STDOUT with stdout_ready_i=1 -> chars 'H', 'i', '\n' appear in order, rvalid_o one cycle after each gnt_o.
- stdout_ready_i=0, nine STDOUT writes with FIFO_DEPTH=8 -> eight grants, then gnt_o=0. Raise ready -> ninth granted in the same cycle as the first pop; STATUS reads count 8.
- Three chars buffered, ready=0, write EXIT=0 -> exit_valid_o stays 0. Raise ready -> exit_valid_o=1 and exit_value_o=0 one cycle after the FIFO empties.
- PASSFAIL=123456789, then EXIT=5 -> tests_passed_o=1, exit_valid_o stays 0. Alternatively PASSFAIL=7 -> tests_failed_o=1.
- Read CYCLE twice, 10 cycles apart -> difference 10. Read an unmapped offset 0x20 -> rdata 0, rvalid_o asserted.
- Assert rst_ni low during DRAIN -> all outputs 0 asynchronously. After release, STATUS reads 0.

Source files
------------

// File: rtl/tb_ctrl_pkg.sv
// Shared definitions for the testbench control responder: register word
// indices within the 64-byte window, the termination FSM states and the
// default value that software writes to report a passing run.
package tb_ctrl_pkg;

   localparam logic [3:0] REG_STDOUT   = 4'h0;
   localparam logic [3:0] REG_EXIT     = 4'h1;
   localparam logic [3:0] REG_PASSFAIL = 4'h2;
   localparam logic [3:0] REG_CYCLE    = 4'h3;
   localparam logic [3:0] REG_STATUS   = 4'h4;

   localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'd123456789;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/tb_ctrl_fifo.sv
// Small synchronous FIFO for stdout characters. Pointers carry one extra MSB
// so that full and empty can be told apart when the index bits are equal.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module tb_ctrl_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             doPush;
   logic             doPop;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign count_o = wrPtr_q - rdPtr_q;
   assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || doPop);

   // Advance the pointers for whichever of push/pop actually happens
   always_comb begin
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, doPush};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
   end

   // Pointer registers; a reset simply discards any buffered characters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate them
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/tb_ctrl_responder.sv
// Memory-mapped control peripheral that software uses to print characters,
// report pass/fail and hand back an exit code. Termination is held off until
// every buffered character has been delivered to the stdout sink.
module tb_ctrl_responder
   import tb_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] PASS_MAGIC = DEFAULT_PASS_MAGIC
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        stdout_valid_o,
   output logic [7:0]  stdout_data_o,
   input  logic        stdout_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          hit;
   logic [3:0]    regIdx;
   logic          isWrite;
   logic          stdoutWrite;
   logic          exitWrite;
   logic          passfailWrite;
   logic          pop;
   logic          fifoFull;
   logic          fifoEmpty;
   logic [7:0]    fifoData;
   logic [CW-1:0] fifoCount;
   logic          unusedBits;

   logic [31:0]   cycle_q;
   logic          rvalid_q;
   logic [31:0]   rdata_q, rdata_d;

   ctrl_state_e   state_q, state_d;
   logic          acceptEvent;
   logic          loadOutputs;

   logic          pendPass_q, pendFail_q, pendExit_q;
   logic [31:0]   exitCode_q;
   logic          passed_q, failed_q, exitValid_q;
   logic [31:0]   exitValue_q;

   assign hit           = (addr_i[31:6] == BASE_ADDR[31:6]);
   assign regIdx        = addr_i[5:2];
   assign isWrite       = req_i && we_i && hit;
   assign stdoutWrite   = isWrite && (regIdx == REG_STDOUT) && be_i[0];
   assign exitWrite     = isWrite && (regIdx == REG_EXIT);
   assign passfailWrite = isWrite && (regIdx == REG_PASSFAIL);
   assign unusedBits    = ^{addr_i[1:0], be_i[3:1]};

   assign pop   = !fifoEmpty && stdout_ready_i;
   assign gnt_o = req_i && !(stdoutWrite && fifoFull && !pop);

   tb_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (stdoutWrite && gnt_o),
      .wdata_i (wdata_i[7:0]),
      .pop_i   (pop),
      .rdata_o (fifoData),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign stdout_valid_o = !fifoEmpty;
   assign stdout_data_o  = fifoEmpty ? 8'h00 : fifoData;

   // Read data mux; misses and write-only registers read as zero
   always_comb begin
      rdata_d = '0;
      if (req_i && !we_i && hit) begin
         case (regIdx)
            REG_CYCLE:  rdata_d = cycle_q;
            REG_STATUS: rdata_d = {21'd0, pendExit_q, pendFail_q, pendPass_q, 8'(fifoCount)};
            default:    rdata_d = '0;
         endcase
      end
   end

   // One-cycle response path and free-running cycle counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         cycle_q  <= '0;
      end else begin
         rvalid_q <= gnt_o;
         rdata_q  <= gnt_o ? rdata_d : 32'd0;
         cycle_q  <= cycle_q + 32'd1;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

   // Termination state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: first termination event starts the drain, empty FIFO ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (exitWrite || passfailWrite) state_d = DRAIN;
         DRAIN:   if (fifoEmpty) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   // Only an event seen in RUN is recorded; outputs load as DONE is entered
   always_comb begin
      acceptEvent = (state_q == RUN) && (exitWrite || passfailWrite);
      loadOutputs = (state_q == DRAIN) && fifoEmpty;
   end

   // Pending termination flags and exit code, first event wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pendPass_q <= 1'b0;
         pendFail_q <= 1'b0;
         pendExit_q <= 1'b0;
         exitCode_q <= '0;
      end else if (acceptEvent) begin
         if (exitWrite) begin
            pendExit_q <= 1'b1;
            exitCode_q <= wdata_i;
         end else if (wdata_i == PASS_MAGIC) begin
            pendPass_q <= 1'b1;
         end else begin
            pendFail_q <= 1'b1;
         end
      end
   end

   // Registered, sticky termination outputs seen by the exit catcher
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         passed_q    <= 1'b0;
         failed_q    <= 1'b0;
         exitValid_q <= 1'b0;
         exitValue_q <= '0;
      end else if (loadOutputs) begin
         passed_q    <= pendPass_q;
         failed_q    <= pendFail_q;
         exitValid_q <= pendExit_q;
         exitValue_q <= pendExit_q ? exitCode_q : 32'd0;
      end
   end

   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;
   assign exit_valid_o   = exitValid_q;
   assign exit_value_o   = exitValue_q;

endmodule

// File: tb/tb_tb_ctrl_responder.sv
// Scoreboard bench for the testbench control responder. Bus stimulus pushes
// expected responses and characters into queues; a monitor pops and compares
// them whenever the design presents rvalid or a stdout handshake.
module tb_tb_ctrl_responder;

   localparam logic [31:0] BASE     = 32'h1000_0000;
   localparam logic [31:0] A_STDOUT = BASE + 32'h00;
   localparam logic [31:0] A_EXIT   = BASE + 32'h04;
   localparam logic [31:0] A_PF     = BASE + 32'h08;
   localparam logic [31:0] A_CYCLE  = BASE + 32'h0C;
   localparam logic [31:0] A_STATUS = BASE + 32'h10;
   localparam logic [31:0] A_UNMAP  = BASE + 32'h20;
   localparam logic [31:0] MAGIC    = 32'd123456789;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = 4'h0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        stdout_valid_o;
   logic [7:0]  stdout_data_o;
   logic        stdout_ready_i = 1'b0;
   logic        tests_passed_o;
   logic        tests_failed_o;
   logic        exit_valid_o;
   logic [31:0] exit_value_o;

   int          checks = 0;
   int          errors = 0;
   int          tbCycle = 0;
   logic [31:0] modelCycle;

   typedef struct {
      int          cyc;
      bit          chk;
      logic [31:0] data;
      string       name;
   } resp_t;

   resp_t       respQ[$];
   logic [7:0]  charQ[$];

   tb_ctrl_responder #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .PASS_MAGIC (MAGIC)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .we_i           (we_i),
      .be_i           (be_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .gnt_o          (gnt_o),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .stdout_valid_o (stdout_valid_o),
      .stdout_data_o  (stdout_data_o),
      .stdout_ready_i (stdout_ready_i),
      .tests_passed_o (tests_passed_o),
      .tests_failed_o (tests_failed_o),
      .exit_valid_o   (exit_valid_o),
      .exit_value_o   (exit_value_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Bench cycle index used to time responses
   always @(posedge clk_i) tbCycle <= tbCycle + 1;

   // Reference cycle counter: cleared by reset, +1 per clock afterwards
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) modelCycle <= '0;
      else         modelCycle <= modelCycle + 32'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: compare bus responses and delivered characters mid-cycle
   always @(negedge clk_i) begin : monitor
      resp_t r;
      #2;
      if (rst_ni) begin
         if (rvalid_o) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpected rvalid", {31'd0, rvalid_o}, 32'd0);
            end else begin
               r = respQ.pop_front();
               checkOutput({r.name, " latency"}, tbCycle, r.cyc);
               if (r.chk) checkOutput({r.name, " rdata"}, rdata_o, r.data);
            end
         end else begin
            checkOutput("idle rdata", rdata_o, 32'd0);
            if (respQ.size() > 0 && respQ[0].cyc < tbCycle) begin
               checkOutput({respQ[0].name, " missing rvalid"}, {31'd0, rvalid_o}, 32'd1);
               void'(respQ.pop_front());
            end
         end
         if (stdout_valid_o && stdout_ready_i) begin
            if (charQ.size() == 0) checkOutput("unexpected char", {31'd0, stdout_valid_o}, 32'd0);
            else                   checkOutput("stdout char", {24'd0, stdout_data_o}, {24'd0, charQ.pop_front()});
         end
      end
   end

   // Issue one bus transfer, wait (bounded) for grant, queue the expected response
   task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input bit chk, input logic [31:0] exp);
      int waitCnt = 0;
      logic [31:0] expData;
      expData = exp;
      @(negedge clk_i);
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
      #1;
      while (!gnt_o && waitCnt < 50) begin
         @(negedge clk_i); #1;
         waitCnt++;
      end
      if (!gnt_o) begin
         checkOutput({name, " grant timeout"}, {31'd0, gnt_o}, 32'd1);
         req_i = 1'b0; we_i = 1'b0;
         return;
      end
      if (!we && addr == A_CYCLE) expData = modelCycle;
      respQ.push_back('{cyc: tbCycle + 1, chk: chk, data: expData, name: name});
      if (we && addr == A_STDOUT && be[0]) charQ.push_back(wdata[7:0]);
      @(posedge clk_i); #1;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(name, 1'b1, addr, data, 4'hF, 1'b1, 32'd0);
   endtask

   task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
      applyStimulus(name, 1'b0, addr, 32'd0, 4'hF, 1'b1, exp);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      do begin
         @(negedge clk_i); #2;
         n++;
      end while (stdout_valid_o && n < 100);
      checkOutput({name, " drained"}, {31'd0, stdout_valid_o}, 32'd0);
      checkOutput({name, " chars left"}, charQ.size(), 32'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " stdout_valid"}, {31'd0, stdout_valid_o}, 32'd0);
      checkOutput({name, " passed"}, {31'd0, tests_passed_o}, 32'd0);
      checkOutput({name, " failed"}, {31'd0, tests_failed_o}, 32'd0);
      checkOutput({name, " exit_valid"}, {31'd0, exit_valid_o}, 32'd0);
      checkOutput({name, " exit_value"}, exit_value_o, 32'd0);
      checkOutput({name, " rvalid"}, {31'd0, rvalid_o}, 32'd0);
   endtask

   task automatic doReset(input string name);
      @(negedge clk_i); #3;
      rst_ni = 1'b0; req_i = 1'b0; stdout_ready_i = 1'b0;
      #1;
      checkAllZero(name);
      respQ.delete();
      charQ.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_i);
      #2;
   endtask

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int w;
      // Reset state
      #7;
      checkAllZero("reset");
      @(negedge clk_i); @(negedge clk_i);
      rst_ni = 1'b1;

      // Three characters with the sink ready
      stdout_ready_i = 1'b1;
      applyStimulus("char H", 1'b1, A_STDOUT, 32'h48, 4'h1, 1'b1, 32'd0);
      applyStimulus("char i", 1'b1, A_STDOUT, 32'h69, 4'h1, 1'b1, 32'd0);
      applyStimulus("char nl", 1'b1, A_STDOUT, 32'h0A, 4'h1, 1'b1, 32'd0);
      waitDrain("hello");

      // Byte lane 0 disabled, out-of-window accesses, reads of write-only regs
      applyStimulus("stdout be0 off", 1'b1, A_STDOUT, 32'h59, 4'hE, 1'b1, 32'd0);
      wr("miss write", BASE + 32'h40, 32'h58);
      rd("miss read", 32'h2000_0010, 32'd0);
      rd("stdout read", A_STDOUT, 32'd0);
      rd("exit read", A_EXIT, 32'd0);
      waitDrain("ignored");

      // Fill the FIFO, ninth write stalls until a pop frees a slot
      stdout_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) wr("fill", A_STDOUT, 32'h41 + i);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = A_STDOUT; wdata_i = 32'h5A; be_i = 4'h1;
      #1 checkOutput("full gnt", {31'd0, gnt_o}, 32'd0);
      @(negedge clk_i);
      #1 checkOutput("full gnt again", {31'd0, gnt_o}, 32'd0);
      @(negedge clk_i);
      stdout_ready_i = 1'b1;
      #1 checkOutput("gnt with pop", {31'd0, gnt_o}, 32'd1);
      respQ.push_back('{cyc: tbCycle + 1, chk: 1'b1, data: 32'd0, name: "ninth"});
      charQ.push_back(8'h5A);
      @(posedge clk_i); #1;
      req_i = 1'b0; we_i = 1'b0; stdout_ready_i = 1'b0;
      rd("status full", A_STATUS, 32'd8);
      stdout_ready_i = 1'b1;
      waitDrain("full");

      // Cycle counter sampled ten cycles apart, unmapped offset
      rd("cycle a", A_CYCLE, 32'd0);
      repeat (9) @(negedge clk_i);
      rd("cycle b", A_CYCLE, 32'd0);
      rd("unmapped", A_UNMAP, 32'd0);

      // Exit is held back until the buffered characters are gone
      stdout_ready_i = 1'b0;
      wr("drain c1", A_STDOUT, 32'h31);
      wr("drain c2", A_STDOUT, 32'h32);
      wr("drain c3", A_STDOUT, 32'h33);
      wr("exit 0", A_EXIT, 32'd0);
      for (int i = 0; i < 3; i++) begin
         waitCycles(1);
         checkOutput("exit held", {31'd0, exit_valid_o}, 32'd0);
      end
      rd("status drain", A_STATUS, 32'h0000_0403);
      @(negedge clk_i);
      stdout_ready_i = 1'b1;
      w = 0;
      do begin
         @(negedge clk_i); #2;
         w++;
      end while (stdout_valid_o && w < 50);
      checkOutput("fifo emptied", {31'd0, stdout_valid_o}, 32'd0);
      checkOutput("exit at empty", {31'd0, exit_valid_o}, 32'd0);
      waitCycles(1);
      checkOutput("exit valid", {31'd0, exit_valid_o}, 32'd1);
      checkOutput("exit value 0", exit_value_o, 32'd0);
      checkOutput("exit no pass", {31'd0, tests_passed_o}, 32'd0);

      // Pass wins over a following exit
      doReset("rst1");
      wr("pf magic", A_PF, MAGIC);
      wr("exit late", A_EXIT, 32'd5);
      waitCycles(2);
      checkOutput("pass flag", {31'd0, tests_passed_o}, 32'd1);
      checkOutput("pass no fail", {31'd0, tests_failed_o}, 32'd0);
      checkOutput("pass no exit", {31'd0, exit_valid_o}, 32'd0);
      checkOutput("pass exit value", exit_value_o, 32'd0);
      rd("status pass", A_STATUS, 32'h0000_0100);

      // Non-magic value signals failure
      doReset("rst2");
      wr("pf 7", A_PF, 32'd7);
      waitCycles(2);
      checkOutput("fail flag", {31'd0, tests_failed_o}, 32'd1);
      checkOutput("fail no pass", {31'd0, tests_passed_o}, 32'd0);
      rd("status fail", A_STATUS, 32'h0000_0200);

      // Exit code carried through, later pass ignored
      doReset("rst3");
      wr("exit code", A_EXIT, 32'hDEAD_BEEF);
      wr("pf after exit", A_PF, MAGIC);
      waitCycles(2);
      checkOutput("exit code valid", {31'd0, exit_valid_o}, 32'd1);
      checkOutput("exit code value", exit_value_o, 32'hDEAD_BEEF);
      checkOutput("exit code no pass", {31'd0, tests_passed_o}, 32'd0);
      rd("status exit", A_STATUS, 32'h0000_0400);

      // Reset asserted while draining
      doReset("rst4");
      stdout_ready_i = 1'b0;
      wr("mid c1", A_STDOUT, 32'h61);
      wr("mid c2", A_STDOUT, 32'h62);
      wr("mid exit", A_EXIT, 32'd3);
      waitCycles(1);
      checkOutput("mid buffered", {31'd0, stdout_valid_o}, 32'd1);
      checkOutput("mid no exit", {31'd0, exit_valid_o}, 32'd0);
      doReset("mid drain reset");
      rd("status after reset", A_STATUS, 32'd0);
      waitCycles(3);
      checkOutput("post reset exit", {31'd0, exit_valid_o}, 32'd0);
      checkOutput("post reset stdout", {31'd0, stdout_valid_o}, 32'd0);

      // Final scoreboard state
      w = 0;
      while (respQ.size() > 0 && w < 10) begin
         @(negedge clk_i); #3;
         w++;
      end
      checkOutput("responses outstanding", respQ.size(), 32'd0);
      checkOutput("chars outstanding", charQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
